// File: rtl/pong_core.sv
// Pong game engine: FSM, ball kinematics, paddle control, scoring and serve.
// Geometry is evaluated once per frame pulse; outputs are registered.
module pong_core #(
  parameter int CORDW   = 10,
  parameter int SCW     = 4,
  parameter int WIN     = 5,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int B_SIZE  = 20,
  parameter int B_VELX  = 9,
  parameter int B_VELY  = 5,
  parameter int VMAX_X  = 14,
  parameter int VMAX_Y  = 10,
  parameter int SPEEDUP = 5,
  parameter int P_ALT   = 48,
  parameter int P_LARG  = 10,
  parameter int P_OFF   = 35,
  parameter int P_VEL   = 7,
  parameter int AI_VEL  = 5
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             frame,
  input  logic             mode,
  input  logic             btn_fire,
  input  logic             btn_pause,
  input  logic             p1_up,
  input  logic             p1_dn,
  input  logic             p2_up,
  input  logic             p2_dn,
  output logic [CORDW-1:0] ball_x,
  output logic [CORDW-1:0] ball_y,
  output logic [CORDW-1:0] pad_l_y,
  output logic [CORDW-1:0] pad_r_y,
  output logic [SCW-1:0]   score_l,
  output logic [SCW-1:0]   score_r,
  output logic [2:0]       game_state,
  output logic [1:0]       winner
);

  // Two guard bits so sums such as x+B_SIZE+vx never wrap.
  localparam int XW = CORDW + 2;
  localparam int HW = $clog2(SPEEDUP + 1);
  typedef logic [XW-1:0] xw_t;
  typedef logic [HW-1:0] hit_t;

  typedef enum logic [2:0] {
    ST_NEW   = 3'd0,
    ST_READY = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_END   = 3'd4
  } state_t;

  localparam xw_t LFACE  = xw_t'(P_OFF + P_LARG);
  localparam xw_t RFACE  = xw_t'(H_RES - P_OFF - P_LARG);
  localparam xw_t RSERVE = xw_t'(H_RES - P_OFF - P_LARG - B_SIZE);
  localparam xw_t BS     = xw_t'(B_SIZE);
  localparam xw_t HR     = xw_t'(H_RES);
  localparam xw_t VR     = xw_t'(V_RES);
  localparam xw_t YMAX   = xw_t'(V_RES - B_SIZE);
  localparam xw_t BCEN   = xw_t'((V_RES - B_SIZE) / 2);
  localparam xw_t PA     = xw_t'(P_ALT);
  localparam xw_t PMAX   = xw_t'(V_RES - P_ALT);
  localparam xw_t PCEN   = xw_t'((V_RES - P_ALT) / 2);
  localparam xw_t PV     = xw_t'(P_VEL);
  localparam xw_t AV     = xw_t'(AI_VEL);
  localparam xw_t VX0    = xw_t'(B_VELX);
  localparam xw_t VY0    = xw_t'(B_VELY);
  localparam xw_t VXMAX  = xw_t'(VMAX_X);
  localparam xw_t VYMAX  = xw_t'(VMAX_Y);
  localparam xw_t HALF_B = xw_t'(B_SIZE / 2);
  localparam xw_t HALF_P = xw_t'(P_ALT / 2);

  function automatic xw_t pad_step(input xw_t pad, input logic up, input logic dn,
                                   input xw_t step);
    xw_t r;
    r = pad;
    if (up && !dn) begin
      if (pad < step) r = '0;
      else            r = pad - step;
    end else if (dn && !up) begin
      if (pad + step > PMAX) r = PMAX;
      else                   r = pad + step;
    end else begin
      r = pad;
    end
    return r;
  endfunction

  function automatic xw_t sat_inc(input xw_t v, input xw_t vmax);
    xw_t r;
    if (v >= vmax) r = vmax;
    else           r = v + xw_t'(1);
    return r;
  endfunction

  state_t         state_q, state_d;
  logic [1:0]     winner_q, winner_d;
  logic [SCW-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  xw_t            ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  xw_t            pad_l_q, pad_l_d, pad_r_q, pad_r_d;
  xw_t            vx_q, vx_d, vy_q, vy_d;
  logic           dir_x_q, dir_x_d;   // 1 = moving right
  logic           dir_y_q, dir_y_d;   // 1 = moving down
  logic           serve_q, serve_d;   // 1 = serve from the right
  hit_t           hits_q, hits_d;
  logic           mode_q, mode_d;
  logic           prev_fire_q, prev_pause_q;

  logic fire_e_s, pause_e_s;
  logic hit_s, point_l_s, point_r_s, ai_up_s, ai_dn_s;
  hit_t hits_inc_s;
  xw_t  ball_c_s, pad_c_s;

  assign fire_e_s  = btn_fire & ~prev_fire_q;
  assign pause_e_s = btn_pause & ~prev_pause_q;

  // Next-state logic for the game FSM and all per-frame kinematics.
  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    pad_l_d    = pad_l_q;
    pad_r_d    = pad_r_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
    serve_d    = serve_q;
    hits_d     = hits_q;
    mode_d     = mode_q;
    hit_s      = 1'b0;
    point_l_s  = 1'b0;
    point_r_s  = 1'b0;
    hits_inc_s = hits_q + hit_t'(1);
    ball_c_s   = ball_y_q + HALF_B;
    pad_c_s    = pad_r_q + HALF_P;
    ai_up_s    = (pad_c_s > ball_c_s + AV);
    ai_dn_s    = (pad_c_s + AV < ball_c_s);

    case (state_q)
      ST_NEW: begin
        score_l_d = '0;
        score_r_d = '0;
        winner_d  = 2'd0;
        serve_d   = 1'b0;
        state_d   = ST_READY;
      end
      ST_READY: begin
        ball_y_d = BCEN;
        pad_l_d  = PCEN;
        pad_r_d  = PCEN;
        vx_d     = VX0;
        vy_d     = VY0;
        hits_d   = '0;
        if (serve_q) begin
          ball_x_d = RSERVE;
          dir_x_d  = 1'b0;
        end else begin
          ball_x_d = LFACE;
          dir_x_d  = 1'b1;
        end
        if (fire_e_s) begin
          state_d = ST_PLAY;
          mode_d  = mode;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_PLAY: begin
        if (pause_e_s) begin
          state_d = ST_PAUSE;
        end else if (frame) begin
          if (!dir_x_q) begin
            if (ball_x_q >= LFACE && ball_x_q <= LFACE + vx_q &&
                ball_y_q + BS > pad_l_q && ball_y_q < pad_l_q + PA) begin
              hit_s    = 1'b1;
              ball_x_d = LFACE;
              dir_x_d  = 1'b1;
            end else if (ball_x_q < vx_q) begin
              point_r_s = 1'b1;
            end else begin
              ball_x_d = ball_x_q - vx_q;
            end
          end else begin
            if (ball_x_q + BS <= RFACE && ball_x_q + BS + vx_q >= RFACE &&
                ball_y_q + BS > pad_r_q && ball_y_q < pad_r_q + PA) begin
              hit_s    = 1'b1;
              ball_x_d = RFACE - BS;
              dir_x_d  = 1'b0;
            end else if (ball_x_q + BS + vx_q >= HR) begin
              point_l_s = 1'b1;
            end else begin
              ball_x_d = ball_x_q + vx_q;
            end
          end

          if (dir_y_q) begin
            if (ball_y_q + BS + vy_q >= VR) begin
              ball_y_d = YMAX;
              dir_y_d  = 1'b0;
            end else begin
              ball_y_d = ball_y_q + vy_q;
            end
          end else begin
            if (ball_y_q < vy_q) begin
              ball_y_d = '0;
              dir_y_d  = 1'b1;
            end else begin
              ball_y_d = ball_y_q - vy_q;
            end
          end

          // Speed increments are applied after this frame's motion.
          if (hit_s) begin
            if (hits_inc_s == hit_t'(SPEEDUP)) begin
              hits_d = '0;
              vx_d   = sat_inc(vx_q, VXMAX);
              vy_d   = sat_inc(vy_q, VYMAX);
            end else begin
              hits_d = hits_inc_s;
            end
          end else begin
            hits_d = hits_q;
          end

          pad_l_d = pad_step(pad_l_q, p1_up, p1_dn, PV);
          if (mode_q) pad_r_d = pad_step(pad_r_q, p2_up, p2_dn, PV);
          else        pad_r_d = pad_step(pad_r_q, ai_up_s, ai_dn_s, AV);

          if (point_r_s) begin
            score_r_d = score_r_q + SCW'(1);
            serve_d   = 1'b1;
            if (score_r_d == SCW'(WIN)) begin
              winner_d = 2'd2;
              state_d  = ST_END;
            end else begin
              state_d = ST_READY;
            end
          end else if (point_l_s) begin
            score_l_d = score_l_q + SCW'(1);
            serve_d   = 1'b0;
            if (score_l_d == SCW'(WIN)) begin
              winner_d = 2'd1;
              state_d  = ST_END;
            end else begin
              state_d = ST_READY;
            end
          end else begin
            state_d = ST_PLAY;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_PAUSE: begin
        if (pause_e_s) state_d = ST_PLAY;
        else           state_d = ST_PAUSE;
      end
      ST_END: begin
        if (fire_e_s) state_d = ST_NEW;
        else          state_d = ST_END;
      end
      default: begin
        state_d = ST_NEW;
      end
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_q      <= ST_NEW;
      winner_q     <= 2'd0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      ball_x_q     <= LFACE;
      ball_y_q     <= BCEN;
      pad_l_q      <= PCEN;
      pad_r_q      <= PCEN;
      vx_q         <= VX0;
      vy_q         <= VY0;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      serve_q      <= 1'b0;
      hits_q       <= '0;
      mode_q       <= 1'b0;
      prev_fire_q  <= 1'b0;
      prev_pause_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      pad_l_q      <= pad_l_d;
      pad_r_q      <= pad_r_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      serve_q      <= serve_d;
      hits_q       <= hits_d;
      mode_q       <= mode_d;
      prev_fire_q  <= btn_fire;
      prev_pause_q <= btn_pause;
    end
  end

  assign ball_x     = ball_x_q[CORDW-1:0];
  assign ball_y     = ball_y_q[CORDW-1:0];
  assign pad_l_y    = pad_l_q[CORDW-1:0];
  assign pad_r_y    = pad_r_q[CORDW-1:0];
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign game_state = state_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_pong_core.sv
// Randomized bench for pong_core against an integer-arithmetic game model.
module tb_pong_core;

  localparam int H_RES = 640, V_RES = 480, B_SIZE = 20;
  localparam int B_VELX = 9, B_VELY = 5, VMAX_X = 14, VMAX_Y = 10;
  localparam int SPEEDUP = 5, WIN = 5;
  localparam int P_ALT = 48, P_LARG = 10, P_OFF = 35, P_VEL = 7, AI_VEL = 5;
  localparam int NCYC = 14000;

  logic clk_pix = 1'b0;
  logic rst_pix;
  logic frame, mode, btn_fire, btn_pause, p1_up, p1_dn, p2_up, p2_dn;
  logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
  logic [3:0] score_l, score_r;
  logic [2:0] game_state;
  logic [1:0] winner;

  pong_core dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .frame(frame), .mode(mode),
    .btn_fire(btn_fire), .btn_pause(btn_pause),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .ball_x(ball_x), .ball_y(ball_y), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
    .score_l(score_l), .score_r(score_r), .game_state(game_state), .winner(winner)
  );

  always #5 clk_pix = ~clk_pix;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
  endtask

  // Reference model: states 0 NEW,1 READY,2 PLAY,3 PAUSE,4 END; dirs are +1/-1.
  int m_state, m_win, m_sl, m_sr, m_bx, m_by, m_pl, m_pr, m_vx, m_vy;
  int m_dx, m_dy, m_serve, m_hits, m_mode, m_pf, m_pp;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int mini(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_state = 0; m_win = 0; m_sl = 0; m_sr = 0;
    m_bx = P_OFF + P_LARG; m_by = (V_RES - B_SIZE) / 2;
    m_pl = (V_RES - P_ALT) / 2; m_pr = m_pl;
    m_vx = B_VELX; m_vy = B_VELY; m_dx = 1; m_dy = 1;
    m_serve = 0; m_hits = 0; m_mode = 0; m_pf = 0; m_pp = 0;
  endtask

  task automatic model_frame();
    int lf, rf, nbx, nby, ndx, ndy, npl, npr, hit, scorer, d, st;
    lf = P_OFF + P_LARG;
    rf = H_RES - lf;
    nbx = m_bx + m_dx * m_vx;
    ndx = m_dx; hit = 0; scorer = 0;
    if (m_dx < 0) begin
      if (m_bx >= lf && nbx <= lf && m_by + B_SIZE > m_pl && m_by < m_pl + P_ALT) begin
        hit = 1; nbx = lf; ndx = 1;
      end else if (nbx < 0) begin
        scorer = 2; nbx = m_bx;
      end
    end else begin
      if (m_bx + B_SIZE <= rf && nbx + B_SIZE >= rf && m_by + B_SIZE > m_pr && m_by < m_pr + P_ALT) begin
        hit = 1; nbx = rf - B_SIZE; ndx = -1;
      end else if (nbx + B_SIZE >= H_RES) begin
        scorer = 1; nbx = m_bx;
      end
    end
    nby = m_by + m_dy * m_vy;
    ndy = m_dy;
    if (nby < 0) begin
      nby = 0; ndy = 1;
    end else if (nby + B_SIZE >= V_RES) begin
      nby = V_RES - B_SIZE; ndy = -1;
    end
    npl = clampi(m_pl + P_VEL * (int'(p1_dn) - int'(p1_up)), 0, V_RES - P_ALT);
    if (m_mode == 1) begin
      npr = clampi(m_pr + P_VEL * (int'(p2_dn) - int'(p2_up)), 0, V_RES - P_ALT);
    end else begin
      d  = (m_by + B_SIZE / 2) - (m_pr + P_ALT / 2);
      st = (d > AI_VEL) ? AI_VEL : ((d < -AI_VEL) ? -AI_VEL : 0);
      npr = clampi(m_pr + st, 0, V_RES - P_ALT);
    end
    if (hit == 1) begin
      m_hits++;
      if (m_hits == SPEEDUP) begin
        m_hits = 0;
        m_vx = mini(m_vx + 1, VMAX_X);
        m_vy = mini(m_vy + 1, VMAX_Y);
      end
    end
    m_bx = nbx; m_by = nby; m_dx = ndx; m_dy = ndy; m_pl = npl; m_pr = npr;
    if (scorer == 2) begin
      m_sr++; m_serve = 1;
      if (m_sr == WIN) begin m_win = 2; m_state = 4; end
      else m_state = 1;
    end else if (scorer == 1) begin
      m_sl++; m_serve = 0;
      if (m_sl == WIN) begin m_win = 1; m_state = 4; end
      else m_state = 1;
    end
  endtask

  task automatic model_step();
    int fe, pe;
    fe = (btn_fire && !m_pf) ? 1 : 0;
    pe = (btn_pause && !m_pp) ? 1 : 0;
    case (m_state)
      0: begin m_sl = 0; m_sr = 0; m_win = 0; m_serve = 0; m_state = 1; end
      1: begin
        m_by = (V_RES - B_SIZE) / 2;
        m_pl = (V_RES - P_ALT) / 2; m_pr = m_pl;
        m_vx = B_VELX; m_vy = B_VELY; m_hits = 0;
        if (m_serve == 0) begin m_bx = P_OFF + P_LARG; m_dx = 1; end
        else begin m_bx = H_RES - P_OFF - P_LARG - B_SIZE; m_dx = -1; end
        if (fe == 1) begin m_state = 2; m_mode = int'(mode); end
      end
      2: begin
        if (pe == 1) m_state = 3;
        else if (frame) model_frame();
      end
      3: if (pe == 1) m_state = 2;
      4: if (fe == 1) m_state = 0;
      default: m_state = 0;
    endcase
    m_pf = int'(btn_fire);
    m_pp = int'(btn_pause);
  endtask

  task automatic compare_all();
    check_eq("state",   int'(game_state), m_state);
    check_eq("winner",  int'(winner),     m_win);
    check_eq("score_l", int'(score_l),    m_sl);
    check_eq("score_r", int'(score_r),    m_sr);
    check_eq("ball_x",  int'(ball_x),     m_bx);
    check_eq("ball_y",  int'(ball_y),     m_by);
    check_eq("pad_l_y", int'(pad_l_y),    m_pl);
    check_eq("pad_r_y", int'(pad_r_y),    m_pr);
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic tick();
    model_step();
    @(posedge clk_pix);
    #1;
    compare_all();
    @(negedge clk_pix);
  endtask

  task automatic do_reset();
    rst_pix = 1'b1;
    #1;
    model_reset();
    check_eq("rst_state",  int'(game_state), 0);
    check_eq("rst_ball_x", int'(ball_x), P_OFF + P_LARG);
    check_eq("rst_ball_y", int'(ball_y), (V_RES - B_SIZE) / 2);
    check_eq("rst_pad_l",  int'(pad_l_y), (V_RES - P_ALT) / 2);
    check_eq("rst_pad_r",  int'(pad_r_y), (V_RES - P_ALT) / 2);
    check_eq("rst_scores", int'(score_l) + int'(score_r), 0);
    check_eq("rst_winner", int'(winner), 0);
    @(negedge clk_pix);
    rst_pix = 1'b0;
  endtask

  task automatic clear_inputs();
    frame = 1'b0; mode = 1'b0; btn_fire = 1'b0; btn_pause = 1'b0;
    p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
  endtask

  task automatic random_paddles(input bit smart1, input bit smart2);
    int bc;
    bc = m_by + B_SIZE / 2;
    if (smart1) begin
      p1_up = (bc < m_pl + P_ALT / 2 - 3); p1_dn = (bc > m_pl + P_ALT / 2 + 3);
    end else begin
      p1_up = 1'($urandom_range(0, 1)); p1_dn = 1'($urandom_range(0, 1));
    end
    if (smart2) begin
      p2_up = (bc < m_pr + P_ALT / 2 - 3); p2_dn = (bc > m_pr + P_ALT / 2 + 3);
    end else begin
      p2_up = 1'($urandom_range(0, 1)); p2_dn = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    bit pause_lvl;
    int sbx, sby, spl, spr, budget;
    pause_lvl = 1'b0;
    clear_inputs();
    do_reset();

    tick();
    check_eq("new_to_ready", int'(game_state), 1);
    btn_fire = 1'b1;
    tick();
    check_eq("ready_to_play", int'(game_state), 2);
    frame = 1'b1;
    tick();
    check_eq("first_frame_x", int'(ball_x), 54);
    check_eq("first_frame_y", int'(ball_y), 235);
    frame = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc == 5000) begin
        budget = 0;
        btn_pause = 1'b0;
        while (m_state != 2 && budget < 500) begin
          frame = 1'b0;
          btn_fire = ~btn_fire;
          btn_pause = (m_state == 3) ? ~btn_pause : 1'b0;
          tick();
          budget++;
        end
        check_eq("reach_play", m_state, 2);
        btn_pause = 1'b0; btn_fire = 1'b0;
        tick();
        sbx = m_bx; sby = m_by; spl = m_pl; spr = m_pr;
        btn_pause = 1'b1; frame = 1'b1;
        tick();
        check_eq("pause_enter", int'(game_state), 3);
        for (int k = 0; k < 40; k++) begin
          frame = (k % 4 == 0);
          btn_fire = 1'($urandom_range(0, 1));
          random_paddles(1'b0, 1'b0);
          tick();
        end
        check_eq("pause_hold_x", int'(ball_x), sbx);
        check_eq("pause_hold_y", int'(ball_y), sby);
        check_eq("pause_hold_pl", int'(pad_l_y), spl);
        check_eq("pause_hold_pr", int'(pad_r_y), spr);
        frame = 1'b0; btn_pause = 1'b0;
        tick();
        btn_pause = 1'b1;
        tick();
        check_eq("pause_resume", int'(game_state), 2);
        check_eq("resume_x", int'(ball_x), sbx);
        check_eq("resume_y", int'(ball_y), sby);
        pause_lvl = 1'b1;
      end
      if (cyc == 9000) begin
        #2;
        do_reset();
        pause_lvl = 1'b0;
        clear_inputs();
      end
      frame = (cyc % 4 == 3);
      btn_fire = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) pause_lvl = ~pause_lvl;
      btn_pause = pause_lvl;
      mode = 1'($urandom_range(0, 1));
      random_paddles(((cyc / 1500) % 2) == 0, ((cyc / 1000) % 3) != 2);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
